// File: rtl/alarm_bank.sv
// alarm_bank: shared tick prescaler feeding NCH independent alarm channels (one-shot or periodic).
// Build option ALARM_SNOOZE_EN adds a per-channel snooze restart out of FIRED.
module alarm_bank #(
    parameter int NCH    = 4,
    parameter int WIDTH  = 8,
    parameter int PRESC  = 1,
    parameter int SNOOZE = 5
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     cfg_we_i,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] cfg_ch_i,
    input  logic [WIDTH-1:0]                         cfg_delay_i,
    input  logic                                     cfg_periodic_i,
    input  logic [NCH-1:0]                           arm_i,
    input  logic [NCH-1:0]                           disarm_i,
    input  logic [NCH-1:0]                           ack_i,
    input  logic [NCH-1:0]                           snooze_i,
    output logic                                     tick_o,
    output logic [NCH-1:0]                           beep_o,
    output logic [NCH-1:0]                           pending_o,
    output logic [NCH-1:0]                           running_o
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FIRED = 2'd2;

    logic [PW-1:0]  presc_q;
    logic [PW-1:0]  presc_d;
    logic           tick;
    logic [NCH-1:0] expire;
    logic [NCH-1:0] beep_q;
    logic [NCH-1:0] pending_q;

    assign tick    = (presc_q == PW'(PRESC - 1));
    assign presc_d = tick ? '0 : presc_q + PW'(1);
    // tick is combinational from the count, so hold it low while reset is applied
    assign tick_o  = tick & ~reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [WIDTH-1:0] cfg_delay_q;
            logic             cfg_per_q;
            logic [WIDTH-1:0] sh_delay_q;
            logic [WIDTH-1:0] sh_delay_d;
            logic             sh_per_q;
            logic             sh_per_d;
            logic [WIDTH-1:0] cnt_q;
            logic [WIDTH-1:0] cnt_d;
            logic [1:0]       state_q;
            logic [1:0]       state_d;
            logic             wr_en;
            logic [WIDTH-1:0] new_delay;
            logic             new_per;
            logic [WIDTH-1:0] last_cnt;
            logic             exp_w;
`ifdef ALARM_SNOOZE_EN
            logic             snz_q;
            logic             snz_d;
`endif

            assign wr_en     = cfg_we_i && (cfg_ch_i == CW'(gi));
            // arm sees a same-cycle config write, so the shadow captures the new values
            assign new_delay = wr_en ? cfg_delay_i : cfg_delay_q;
            assign new_per   = wr_en ? cfg_periodic_i : cfg_per_q;

`ifdef ALARM_SNOOZE_EN
            assign last_cnt = snz_q ? WIDTH'(SNOOZE - 1)
                                    : ((sh_delay_q == '0) ? '0 : sh_delay_q - WIDTH'(1));
`else
            assign last_cnt = (sh_delay_q == '0) ? '0 : sh_delay_q - WIDTH'(1);
`endif

            always_comb begin
                state_d    = state_q;
                cnt_d      = cnt_q;
                sh_delay_d = sh_delay_q;
                sh_per_d   = sh_per_q;
                exp_w      = 1'b0;
`ifdef ALARM_SNOOZE_EN
                snz_d      = snz_q;
`endif
                if (disarm_i[gi]) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
`ifdef ALARM_SNOOZE_EN
                    snz_d   = 1'b0;
`endif
                end else if (arm_i[gi]) begin
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                    sh_delay_d = new_delay;
                    sh_per_d   = new_per;
`ifdef ALARM_SNOOZE_EN
                    snz_d      = 1'b0;
`endif
                end
`ifdef ALARM_SNOOZE_EN
                else if (snooze_i[gi] && (state_q == ST_FIRED)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    snz_d   = 1'b1;
                end
`endif
                else if ((state_q == ST_RUN) && tick) begin
                    if (cnt_q == last_cnt) begin
                        exp_w = 1'b1;
                        cnt_d = '0;
                        if (!sh_per_q) begin
                            state_d = ST_FIRED;
                        end
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    cfg_delay_q <= '0;
                    cfg_per_q   <= 1'b0;
                    sh_delay_q  <= '0;
                    sh_per_q    <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= ST_IDLE;
`ifdef ALARM_SNOOZE_EN
                    snz_q       <= 1'b0;
`endif
                end else begin
                    if (wr_en) begin
                        cfg_delay_q <= cfg_delay_i;
                        cfg_per_q   <= cfg_periodic_i;
                    end
                    sh_delay_q <= sh_delay_d;
                    sh_per_q   <= sh_per_d;
                    cnt_q      <= cnt_d;
                    state_q    <= state_d;
`ifdef ALARM_SNOOZE_EN
                    snz_q      <= snz_d;
`endif
                end
            end

            assign expire[gi]    = exp_w;
            assign running_o[gi] = (state_q == ST_RUN);
        end
    endgenerate

`ifndef ALARM_SNOOZE_EN
    logic unused_snooze;
    assign unused_snooze = ^snooze_i;
`endif

    // a same-cycle ack loses to a new expiry so the event is never dropped
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            beep_q    <= '0;
            pending_q <= '0;
        end else begin
            beep_q    <= expire;
            pending_q <= expire | (pending_q & ~ack_i);
        end
    end

    assign beep_o    = beep_q;
    assign pending_o = pending_q;

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank: a per-cycle vector table on a PRESC=1 instance plus
// hand sequences for reset, snooze and a PRESC=4 / NCH=3 instance.
module tb_alarm_bank;

`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset = 1'b1;

    logic       a_we = 1'b0;
    logic [1:0] a_ch = '0;
    logic [7:0] a_dly = '0;
    logic       a_per = 1'b0;
    logic [3:0] a_arm = '0, a_dis = '0, a_ack = '0, a_snz = '0;
    logic       a_tick;
    logic [3:0] a_beep, a_pend, a_run;

    logic       b_we = 1'b0;
    logic [1:0] b_ch = '0;
    logic [7:0] b_dly = '0;
    logic       b_per = 1'b0;
    logic [2:0] b_arm = '0, b_dis = '0, b_ack = '0, b_snz = '0;
    logic       b_tick;
    logic [2:0] b_beep, b_pend, b_run;

    alarm_bank #(.NCH(4), .WIDTH(8), .PRESC(1), .SNOOZE(5)) dut_a (
        .clock(clock), .reset(reset),
        .cfg_we_i(a_we), .cfg_ch_i(a_ch), .cfg_delay_i(a_dly), .cfg_periodic_i(a_per),
        .arm_i(a_arm), .disarm_i(a_dis), .ack_i(a_ack), .snooze_i(a_snz),
        .tick_o(a_tick), .beep_o(a_beep), .pending_o(a_pend), .running_o(a_run)
    );

    alarm_bank #(.NCH(3), .WIDTH(8), .PRESC(4), .SNOOZE(5)) dut_b (
        .clock(clock), .reset(reset),
        .cfg_we_i(b_we), .cfg_ch_i(b_ch), .cfg_delay_i(b_dly), .cfg_periodic_i(b_per),
        .arm_i(b_arm), .disarm_i(b_dis), .ack_i(b_ack), .snooze_i(b_snz),
        .tick_o(b_tick), .beep_o(b_beep), .pending_o(b_pend), .running_o(b_run)
    );

    typedef struct {
        logic       we;
        logic [1:0] ch;
        logic [7:0] dly;
        logic       per;
        logic [3:0] arm;
        logic [3:0] dis;
        logic [3:0] ack;
        logic [3:0] beep;
        logic [3:0] pend;
        logic [3:0] run;
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic void add(input logic we, input logic [1:0] ch, input logic [7:0] dly,
                                input logic per, input logic [3:0] arm, input logic [3:0] dis,
                                input logic [3:0] ack, input logic [3:0] beep,
                                input logic [3:0] pend, input logic [3:0] run);
        vec_t v;
        v.we = we; v.ch = ch; v.dly = dly; v.per = per;
        v.arm = arm; v.dis = dis; v.ack = ack;
        v.beep = beep; v.pend = pend; v.run = run;
        vq.push_back(v);
    endfunction

    function automatic void idle(input logic [3:0] beep, input logic [3:0] pend, input logic [3:0] run);
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h0, beep, pend, run);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int nb;

        // reset held for two cycles: every output low throughout
        for (int k = 0; k < 2; k++) begin
            step();
            check($sformatf("rst%0d tick_a", k), 32'(a_tick), 32'd0);
            check($sformatf("rst%0d tick_b", k), 32'(b_tick), 32'd0);
            check($sformatf("rst%0d outs_a", k), 32'({a_beep, a_pend, a_run}), 32'd0);
            check($sformatf("rst%0d outs_b", k), 32'({b_beep, b_pend, b_run}), 32'd0);
        end
        reset = 1'b0;
        #1;
        check("tick_a presc1", 32'(a_tick), 32'd1);

        // ch0 delay 10 one-shot: beep 11 cycles after arm, pending until ack
        add(1'b1, 2'd0, 8'd10, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
        for (int k = 0; k < 9; k++) idle(4'h0, 4'h0, 4'h1);
        idle(4'h1, 4'h1, 4'h0);
        idle(4'h0, 4'h1, 4'h0);
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);
        // ch3 write+arm same cycle with delay 2, ack coincident with expiry
        add(1'b1, 2'd3, 8'd2, 1'b0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8);
        idle(4'h0, 4'h0, 4'h8);
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0);
        idle(4'h0, 4'h8, 4'h0);
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0);
        // ch2 delay 0 behaves as 1: beep 2 cycles after arm
        add(1'b1, 2'd2, 8'd0, 1'b0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4);
        idle(4'h4, 4'h4, 4'h0);
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h0);
        // arm and disarm together: disarm wins
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'h4, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
        idle(4'h0, 4'h0, 4'h0);
        // ch1 delay 4, rewritten to 50 mid-run: current period keeps 4
        add(1'b1, 2'd1, 8'd4, 1'b0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2);
        add(1'b1, 2'd1, 8'd50, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2);
        idle(4'h0, 4'h0, 4'h2);
        idle(4'h0, 4'h0, 4'h2);
        idle(4'h2, 4'h2, 4'h0);
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0);
        // re-arm picks up delay 50: no beep where 4 would have expired
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2);
        for (int k = 0; k < 4; k++) idle(4'h0, 4'h0, 4'h2);
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
        // two channels expiring on the same cycle
        add(1'b1, 2'd0, 8'd3, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1'b1, 2'd3, 8'd3, 1'b0, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 4'h9);
        idle(4'h0, 4'h0, 4'h9);
        idle(4'h0, 4'h0, 4'h9);
        idle(4'h9, 4'h9, 4'h0);
        add(1'b0, 2'd0, 8'd0, 1'b0, 4'h0, 4'h0, 4'h9, 4'h0, 4'h0, 4'h0);

        for (int i = 0; i < vq.size(); i++) begin
            a_we = vq[i].we; a_ch = vq[i].ch; a_dly = vq[i].dly; a_per = vq[i].per;
            a_arm = vq[i].arm; a_dis = vq[i].dis; a_ack = vq[i].ack;
            step();
            check($sformatf("v%0d beep", i), 32'(a_beep), 32'(vq[i].beep));
            check($sformatf("v%0d pending", i), 32'(a_pend), 32'(vq[i].pend));
            check($sformatf("v%0d running", i), 32'(a_run), 32'(vq[i].run));
        end
        a_we = 1'b0; a_arm = '0; a_dis = '0; a_ack = '0;

        // reset mid-count: immediate clear, no beep afterwards
        a_arm = 4'h1;
        step();
        a_arm = 4'h0;
        check("midrst armed", 32'(a_run), 32'h1);
        step();
        reset = 1'b1;
        #1;
        check("midrst async run", 32'(a_run), 32'd0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("midrst quiet%0d", k), 32'({a_beep, a_pend, a_run}), 32'd0);
        end
        // config was cleared too: delay back to 0, so beep 2 cycles after arm
        a_arm = 4'h1;
        step();
        a_arm = 4'h0;
        check("cfgrst run", 32'(a_run), 32'h1);
        step();
        check("cfgrst beep", 32'(a_beep), 32'h1);
        check("cfgrst fired", 32'(a_run), 32'h0);

        // snooze from FIRED
        a_snz = 4'h1;
        for (int k = 1; k <= 8; k++) begin
            step();
            a_snz = 4'h0;
            check($sformatf("snooze k%0d beep", k), 32'(a_beep), 32'(SNZ && (k == 6)));
            check($sformatf("snooze k%0d run", k), 32'(a_run), 32'(SNZ && (k <= 5)));
        end

        // PRESC=4 instance: tick every fourth cycle
        n = 0;
        while (!b_tick && n < 8) begin
            step();
            n++;
        end
        check("b first tick", 32'(b_tick), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("b tick k%0d", k), 32'(b_tick), 32'((k % 4) == 0));
        end

        // out-of-range channel write leaves the reset config (delay 0, one-shot)
        b_we = 1'b1; b_ch = 2'd3; b_dly = 8'd2; b_per = 1'b1;
        step();
        b_we = 1'b0;
        b_arm = 3'h7;
        step();
        b_arm = 3'h0;
        check("b arm all", 32'(b_run), 32'h7);
        n = 0;
        do begin
            step();
            n++;
        end while (b_beep == 3'h0 && n < 10);
        check("b oor beep", 32'(b_beep), 32'h7);
        check("b oor oneshot", 32'(b_run), 32'h0);
        b_ack = 3'h7;
        step();
        b_ack = 3'h0;
        check("b oor ack", 32'(b_pend), 32'h0);

        // ch1 delay 3 periodic: beep every 12 cycles, then disarm stops it
        b_we = 1'b1; b_ch = 2'd1; b_dly = 8'd3; b_per = 1'b1;
        step();
        b_we = 1'b0;
        b_arm = 3'h2;
        step();
        b_arm = 3'h0;
        n = 0;
        do begin
            step();
            n++;
        end while (!b_beep[1] && n < 20);
        check("b per first", 32'(b_beep[1]), 32'd1);
        for (int r = 0; r < 2; r++) begin
            n = 0;
            do begin
                step();
                n++;
            end while (!b_beep[1] && n < 20);
            check($sformatf("b period%0d", r), 32'(n), 32'd12);
        end
        b_dis = 3'h2;
        step();
        b_dis = 3'h0;
        check("b disarm run", 32'(b_run), 32'h0);
        nb = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (b_beep[1]) nb++;
        end
        check("b no beep after disarm", 32'(nb), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
